// File: rtl/scan_mux_pkg.sv
// scan_mux_pkg: shared definitions for the scan multiplexer.
//   state_t   - controller mode encoding (MANUAL=0, SCAN=1)
//   clog2     - ceiling log2 for sizing index fields at elaboration
//   sel_width - channel index width, never narrower than one bit
package scan_mux_pkg;

    // Controller mode: operator-selected channel or automatic round-robin.
    typedef enum logic {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } state_t;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        if (n > 1) begin
            for (int unsigned i = 0; i < 32; i++) begin
                if (((n - 1) >> i) != 0) begin
                    r = i + 1;
                end
            end
        end
        return r;
    endfunction

    // Width of an index able to address n items, at least one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        int unsigned w;
        w = clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// dwell_timer: per-channel dwell counter with live terminal-count compare.
//   clk, rst_n - clock and asynchronous active-low reset
//   clear      - synchronous clear, wins over enable
//   enable     - count one cycle; wraps to zero on terminal count
//   dwell      - cycles per channel, sampled every cycle; 0 acts as 1
//   tc         - combinational: count has reached max(dwell,1)-1 (or passed it)
module dwell_timer #(
    parameter int unsigned DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               enable,
    input  logic [DWELL_W-1:0] dwell,
    output logic               tc
);

    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] limit;

    // ">=" rather than "==" so that lowering dwell below the running
    // count still produces a terminal count on the very next edge.
    always_comb begin
        limit = '0;
        if (dwell != '0) begin
            limit = dwell - DWELL_W'(1);
        end
        tc = (cnt >= limit);
    end

    // Counter: clear has priority, otherwise count and restart at tc.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            if (tc) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + DWELL_W'(1);
            end
        end
    end

endmodule

// File: rtl/scan_mux.sv
// scan_mux: NCH-way data multiplexer with manual select and timed auto-scan.
//   clk, rst_n - clock and asynchronous active-low reset
//   din        - NCH packed channels, channel k at [k*WIDTH +: WIDTH]
//   sel, load  - manual channel index and its one-cycle capture strobe
//   auto_en    - level: 1 selects auto-scan, 0 manual
//   dwell      - cycles spent on each channel while scanning (0 acts as 1)
//   dout       - din of the current channel, one cycle late
//   ch         - current channel index
//   ch_chg     - one-cycle pulse, high in the cycle ch holds a new value
//   sel_err    - one-cycle pulse after a load whose sel is out of range
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter  int unsigned WIDTH   = 1,
    parameter  int unsigned NCH     = 4,
    parameter  int unsigned DWELL_W = 16,
    localparam int unsigned SELW    = sel_width(NCH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH*WIDTH-1:0]   din,
    input  logic [SELW-1:0]        sel,
    input  logic                   load,
    input  logic                   auto_en,
    input  logic [DWELL_W-1:0]     dwell,
    output logic [WIDTH-1:0]       dout,
    output logic [SELW-1:0]        ch,
    output logic                   ch_chg,
    output logic                   sel_err
);

    // Bit offset of the selected channel inside din.
    localparam int unsigned DINW = NCH * WIDTH;
    localparam int unsigned IDXW = sel_width(DINW);

    state_t          state;
    state_t          state_nxt;
    logic [SELW-1:0] ch_nxt;
    logic [SELW-1:0] ch_inc;
    logic [IDXW-1:0] base;
    logic            load_ok;
    logic            load_bad;
    logic            scan_run;
    logic            tmr_clear;
    logic            tmr_tc;

    // Next-channel and mode decisions.
    always_comb begin
        load_ok   = load && (32'(sel) < NCH);
        load_bad  = load && !load_ok;
        // Scanning only advances while the mode is SCAN and stays SCAN;
        // the edge that drops auto_en holds the channel.
        scan_run  = (state == SCAN) && auto_en;
        // Counter sits at zero in MANUAL so every scan entry starts a full
        // dwell; a valid load restarts the dwell on the new channel.
        tmr_clear = (state == MANUAL) || load_ok;

        ch_inc = ch + SELW'(1);
        if (ch == SELW'(NCH - 1)) begin
            ch_inc = '0;
        end

        // A valid load beats a same-cycle scan advance.
        ch_nxt = ch;
        if (load_ok) begin
            ch_nxt = sel;
        end else if (scan_run && tmr_tc) begin
            ch_nxt = ch_inc;
        end

        state_nxt = auto_en ? SCAN : MANUAL;

        // ch is always below NCH, so the offset stays inside din.
        base = IDXW'(ch) * IDXW'(WIDTH);
    end

    dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_dwell_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (tmr_clear),
        .enable (scan_run),
        .dwell  (dwell),
        .tc     (tmr_tc)
    );

    // Mode, channel and all outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= MANUAL;
            ch      <= '0;
            dout    <= '0;
            ch_chg  <= 1'b0;
            sel_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            ch      <= ch_nxt;
            dout    <= din[base +: WIDTH];
            ch_chg  <= (ch_nxt != ch);
            sel_err <= load_bad;
        end
    end

endmodule
